sec_serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor. Computes diff = a - b modulo 2^WIDTH and reports a borrow flag.
- Companion to the section's parallel 4-bit adder: same operand format (two unsigned nibbles), but the inverse operation.
- Processed LSB-first, one bit per clock, to trade latency for area on the tile.
- Sits between the input pin decode and the output mux. Uses a start/busy/done handshake with registered results.

---
 rtl/sec_serial_subtractor.sv | 128 ++++++++++++
 tb/tb_sec_serial_subtractor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sec_serial_subtractor.sv
// rtl/sec_serial_subtractor.sv - bit-serial WIDTH-bit unsigned subtractor with start/busy/done handshake
//
// Computes diff = (a - b) mod 2^WIDTH LSB-first, one bit per clock, and
// reports borrow (a < b) and zero (diff == 0). All outputs are registered.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request pulse, sampled every rising edge (ignored while busy)
//   a, b   - unsigned minuend / subtrahend, captured when start is accepted
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when diff/borrow/zero are updated
//   diff   - registered result (a - b) mod 2^WIDTH
//   borrow - registered, 1 iff a < b
//   zero   - registered, 1 iff diff == 0
module sec_serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  // Full-subtractor slice on the current LSBs.
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;

  assign d_bit   = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // Difference bits enter at the MSB so the LSB-first stream lands in order.
  assign sd_next = {d_bit, sd[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          // start is deliberately not looked at here: an operation in flight
          // runs to completion on the operands it captured.
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= br_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= sd_next;
            borrow <= br_next;
            zero   <= (sd_next == '0);
            state  <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          // Back-to-back: a start in the done cycle goes straight to RUN.
          if (start) begin
            sa    <= a;
            sb    <= b;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_serial_subtractor.sv
// tb/tb_sec_serial_subtractor.sv - self-checking bench for sec_serial_subtractor
module tb_sec_serial_subtractor;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  int tests;
  int failed;

  // Last result the DUT is expected to be holding.
  logic [WIDTH-1:0] prev_diff;
  logic             prev_borrow;
  logic             prev_zero;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_borrow;
    logic             exp_zero;
  } vec_t;

  vec_t vecs [6];

  sec_serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; sample point is 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       output logic [WIDTH-1:0] md, output logic mbr, output logic mz);
    int full;
    full = int'(ma) - int'(mb);
    mbr  = (full < 0);
    md   = WIDTH'(full);
    mz   = (md == '0);
  endtask

  // Applies start in the current cycle, checks busy/hold through RUN and the
  // result in the done cycle. Returns positioned in the done cycle.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input string tag);
    logic [WIDTH-1:0] md;
    logic             mbr;
    logic             mz;
    model(oa, ob, md, mbr, mz);
    a     = oa;
    b     = ob;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    for (int i = 1; i <= WIDTH; i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " done_low"}, done, 0);
      check({tag, " diff_hold"}, diff, prev_diff);
      check({tag, " borrow_hold"}, borrow, prev_borrow);
      check({tag, " zero_hold"}, zero, prev_zero);
      if (i < WIDTH) step();
    end
    step();
    check({tag, " done"}, done, 1);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " diff"}, diff, md);
    check({tag, " borrow"}, borrow, mbr);
    check({tag, " zero"}, zero, mz);
    prev_diff   = md;
    prev_borrow = mbr;
    prev_zero   = mz;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd9,  4'hA,  1'b1, 1'b0};
    vecs[2] = '{4'd0,  4'd15, 4'd1,  1'b1, 1'b0};
    vecs[3] = '{4'd15, 4'd0,  4'd15, 1'b0, 1'b0};
    vecs[4] = '{4'd7,  4'd7,  4'd0,  1'b0, 1'b1};
    vecs[5] = '{4'd5,  4'd2,  4'd3,  1'b0, 1'b0};

    step();
    step();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow, 0);
    check("reset zero", zero, 1);
    prev_diff   = '0;
    prev_borrow = 1'b0;
    prev_zero   = 1'b1;

    // Table vectors; entries after the first start in the previous done
    // cycle, so 7-7 followed by 5-2 is the back-to-back case.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].va, vecs[i].vb, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table_diff", i), diff, vecs[i].exp_diff);
      check($sformatf("vec%0d table_borrow", i), borrow, vecs[i].exp_borrow);
      check($sformatf("vec%0d table_zero", i), zero, vecs[i].exp_zero);
    end
    step();
    check("idle done_low", done, 0);
    check("idle busy_low", busy, 0);
    check("idle diff_hold", diff, 3);

    // start during RUN is ignored and operands are not re-captured.
    a = 4'd9; b = 4'd3; start = 1'b1;
    step();                       // cycle 1
    start = 1'b0;
    step();                       // cycle 2
    a = 4'd1; b = 4'd2; start = 1'b1;
    step();                       // cycle 3
    start = 1'b0; a = 4'd15; b = 4'd15;
    check("ignore busy c3", busy, 1);
    step();                       // cycle 4
    check("ignore done c4", done, 0);
    step();                       // cycle 5
    check("ignore done c5", done, 1);
    check("ignore diff", diff, 6);
    check("ignore borrow", borrow, 0);
    step();
    check("ignore no_restart busy", busy, 0);
    check("ignore no_second_done", done, 0);

    // Reset mid-RUN aborts with no done pulse.
    a = 4'd9; b = 4'd3; start = 1'b1;
    step();                       // cycle 1
    start = 1'b0;
    step();                       // cycle 2
    step();                       // cycle 3
    rst = 1'b1;
    step();                       // cycle 4
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort diff", diff, 0);
    check("abort borrow", borrow, 0);
    check("abort zero", zero, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort no_done", done, 0);
      check("abort stays idle", busy, 0);
    end
    prev_diff   = '0;
    prev_borrow = 1'b0;
    prev_zero   = 1'b1;
    do_op(4'd8, 4'd1, "after_abort");
    check("after_abort diff7", diff, 7);
    step();

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      do_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
